// File: rtl/mult_booth_ctrl_if.sv
// mult_booth_ctrl_if: request/datapath control bundle for the Booth multiplier sequencer (ack only with MULT_CTRL_ACK_EN)
interface mult_booth_ctrl_if #(parameter int N = 8) ();
  localparam int CNT_W = $clog2(N + 1);
  logic start;
  logic abort;
  logic [1:0] q_lsb;
  logic dp_clr;
  logic load_a;
  logic load_b;
  logic load_add;
  logic shift;
  logic add_sub;
  logic busy;
  logic done;
  logic [CNT_W-1:0] iter;
`ifdef MULT_CTRL_ACK_EN
  logic ack;
`endif
  modport master (
    output start, abort, q_lsb,
`ifdef MULT_CTRL_ACK_EN
    ack,
`endif
    input dp_clr, load_a, load_b, load_add, shift, add_sub, busy, done, iter
  );
  modport slave (
    input start, abort, q_lsb,
`ifdef MULT_CTRL_ACK_EN
    ack,
`endif
    output dp_clr, load_a, load_b, load_add, shift, add_sub, busy, done, iter
  );
endinterface

// File: rtl/mult_booth_ctrl.sv
// mult_booth_ctrl: radix-2 Booth sequential multiplier sequencer; MULT_CTRL_ACK_EN holds done until ack
module mult_booth_ctrl #(
  parameter int N = 8,
  localparam int CNT_W = $clog2(N + 1)
) (
  input logic clk,
  input logic rst,
  mult_booth_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, EVAL, SHIFT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] iter;
  logic run;
  assign run = (state == CLEAR) || (state == LOAD) || (state == EVAL) || (state == SHIFT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      iter <= '0;
    end else if (run && bus.abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= bus.start ? CLEAR : IDLE;
        CLEAR: begin
          iter <= '0;
          state <= LOAD;
        end
        LOAD: state <= EVAL;
        EVAL: state <= SHIFT;
        SHIFT: begin
          if (iter != CNT_W'(N)) iter <= iter + 1'b1;
          state <= (iter == CNT_W'(N - 1)) ? DONE : EVAL;
        end
`ifdef MULT_CTRL_ACK_EN
        DONE: state <= bus.ack ? IDLE : DONE;
`else
        DONE: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  // controls decode the registered state only; q_lsb comes from datapath registers
  assign bus.dp_clr = state == CLEAR;
  assign bus.load_a = state == LOAD;
  assign bus.load_b = state == LOAD;
  assign bus.load_add = (state == EVAL) && (bus.q_lsb[1] ^ bus.q_lsb[0]);
  assign bus.add_sub = (state == EVAL) && (bus.q_lsb == 2'b01);
  assign bus.shift = state == SHIFT;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.iter = iter;
endmodule
